// File: rtl/lfsr_run_ctrl.sv
// lfsr_run_ctrl: sequences a 5-bit Fibonacci LFSR core through a single run of a requested length.
// Ports:
//   clk, nrst           clock (rising edge) and asynchronous active-low reset
//   start, abort        run request (sampled in IDLE) and run cancel (LOAD/RUN)
//   seed_in, len_in     requested seed (0 selects SEED_DEF) and number of output bits
//   sel_in              requested output bit, clamped to WIDTH-1
//   lfsr_state          current contents of the LFSR core
//   lfsr_load/seed/en   core load strobe, seed value and step enable
//   mux_sel, bit_valid  output bit select and qualifier for the muxed bit
//   busy, done          run in progress (LOAD/RUN) and one-cycle completion pulse
//   period_found/out    seed recurrence flag and measured period
//   lockup_err          all-zero state was observed during the run
module lfsr_run_ctrl #(
    parameter int               WIDTH    = 5,
    parameter int               CNT_W    = 16,
    parameter int               SEL_W    = 3,
    parameter logic [WIDTH-1:0] SEED_DEF = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [CNT_W-1:0] len_in,
    input  logic [SEL_W-1:0] sel_in,
    input  logic [WIDTH-1:0] lfsr_state,
    output logic             lfsr_load,
    output logic [WIDTH-1:0] lfsr_seed,
    output logic             lfsr_en,
    output logic [SEL_W-1:0] mux_sel,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic             period_found,
    output logic [CNT_W-1:0] period_out,
    output logic             lockup_err
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(WIDTH - 1);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [CNT_W-1:0] len_q, len_d, k_q, k_d, period_q, period_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             pf_q, pf_d, lockup_q, lockup_d, lock;
    always_comb begin
        lock     = lfsr_state == '0;
        state_d  = state_q;
        seed_d   = seed_q;
        len_d    = len_q;
        sel_d    = sel_q;
        k_d      = k_q;
        pf_d     = pf_q;
        period_d = period_q;
        lockup_d = lockup_q;
        case (state_q)
            IDLE: if (start) begin
                seed_d   = (seed_in == '0) ? SEED_DEF : seed_in;
                len_d    = len_in;
                sel_d    = (sel_in > SEL_MAX) ? SEL_MAX : sel_in;
                k_d      = '0;
                pf_d     = 1'b0;
                period_d = '0;
                lockup_d = 1'b0;
                state_d  = (len_in == '0) ? DONE : LOAD;
            end
            LOAD: state_d = abort ? DONE : RUN;
            RUN: begin
                k_d      = (k_q == '1) ? k_q : k_q + 1'b1;
                lockup_d = lockup_q | lock;
                // k==0 always sees the seed itself, so only later recurrences count
                if (!pf_q && k_q != '0 && lfsr_state == seed_q) begin
                    pf_d     = 1'b1;
                    period_d = k_q;
                end
                if (abort || lock || k_q == len_q - 1'b1) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            seed_q   <= SEED_DEF;
            len_q    <= '0;
            sel_q    <= '0;
            k_q      <= '0;
            pf_q     <= 1'b0;
            period_q <= '0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            len_q    <= len_d;
            sel_q    <= sel_d;
            k_q      <= k_d;
            pf_q     <= pf_d;
            period_q <= period_d;
            lockup_q <= lockup_d;
        end
    end
    // abort and lock-up must stop the core in the very cycle they are seen
    assign lfsr_en      = state_q == RUN && !abort && !lock;
    assign bit_valid    = lfsr_en;
    assign lfsr_load    = state_q == LOAD;
    assign lfsr_seed    = seed_q;
    assign mux_sel      = sel_q;
    assign busy         = state_q == LOAD || state_q == RUN;
    assign done         = state_q == DONE;
    assign period_found = pf_q;
    assign period_out   = period_q;
    assign lockup_err   = lockup_q;
endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// tb_lfsr_run_ctrl: scoreboard bench for lfsr_run_ctrl driving a behavioural x^5+x^3+1 LFSR core.
module tb_lfsr_run_ctrl;
    logic        clk = 1'b0, nrst = 1'b0, start = 1'b0, abort = 1'b0;
    logic [4:0]  seed_in = '0, lfsr_state = '0, lfsr_seed;
    logic [15:0] len_in = '0, period_out;
    logic [2:0]  sel_in = '0, mux_sel;
    logic        lfsr_load, lfsr_en, bit_valid, busy, done, period_found, lockup_err;
    int          checks = 0, errors = 0, load_cnt = 0, zero_at = -1, en_cnt = 0;
    logic        exp_q[$];

    lfsr_run_ctrl dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .seed_in(seed_in), .len_in(len_in), .sel_in(sel_in), .lfsr_state(lfsr_state),
        .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_en(lfsr_en), .mux_sel(mux_sel),
        .bit_valid(bit_valid), .busy(busy), .done(done), .period_found(period_found),
        .period_out(period_out), .lockup_err(lockup_err)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] nxt(input logic [4:0] s);
        return {s[3:0], s[4] ^ s[2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // behavioural core; zero_at forces the all-zero state into that RUN cycle
    always @(posedge clk) begin
        if (lfsr_load) begin
            lfsr_state <= lfsr_seed;
            en_cnt     <= 0;
        end else if (lfsr_en) begin
            en_cnt     <= en_cnt + 1;
            lfsr_state <= (en_cnt + 1 == zero_at) ? 5'd0 : nxt(lfsr_state);
        end
    end

    always @(negedge clk) begin
        #2;
        if (lfsr_load) load_cnt++;
        if (bit_valid) begin
            if (exp_q.size() == 0) check("bit_extra", 1, 0);
            else check("bit", {31'd0, lfsr_state[mux_sel]}, {31'd0, exp_q.pop_front()});
        end
    end

    task automatic check_reset_outs(input string tag);
        check(tag, {lfsr_load, lfsr_en, lfsr_seed, mux_sel, bit_valid, busy, done,
                    period_found, period_out, lockup_err},
              {1'b0, 1'b0, 5'd1, 3'd0, 4'b0, 16'd0, 1'b0});
    endtask

    task automatic do_run(input logic [4:0] sd, input int len, input logic [2:0] sl,
                          input int za, input int abort_at, input int extra_start, input int rst_at);
        logic [4:0] eseed, s;
        logic [2:0] esel;
        logic       epf, elock, seen;
        int         last, nbits, eper, elat, c;
        eseed = (sd == 5'd0) ? 5'd1 : sd;
        esel  = (sl > 3'd4) ? 3'd4 : sl;
        last  = len - 1;
        if (za >= 0 && za < last) last = za;
        if (abort_at >= 0 && abort_at < last) last = abort_at;
        elock = za >= 0 && za <= last;
        nbits = last + 1 - (((elock && za == last) || abort_at == last) ? 1 : 0);
        s = eseed;
        for (int k = 0; k < nbits; k++) begin
            exp_q.push_back(s[esel]);
            s = nxt(s);
        end
        s = eseed; epf = 1'b0; eper = 0;
        for (int k = 1; k <= last; k++) begin
            s = nxt(s);
            if (elock && k == za) break;
            if (!epf && s == eseed) begin epf = 1'b1; eper = k; end
        end
        elat = (len == 0) ? 1 : last + 3;
        @(negedge clk);
        zero_at = za; load_cnt = 0;
        seed_in = sd; len_in = len[15:0]; sel_in = sl; start = 1'b1;
        seen = 1'b0;
        for (c = 1; c <= len + 10; c++) begin
            @(negedge clk);
            start = extra_start >= 0 && c == extra_start + 2;
            abort = abort_at >= 0 && c == abort_at + 2;
            if (rst_at >= 0 && c == rst_at + 2) begin
                nrst = 1'b0;
                #1;
                check_reset_outs("rst_mid_run");
                exp_q.delete();
                @(negedge clk);
                nrst = 1'b1;
                zero_at = -1;
                return;
            end
            #1;
            if (abort) check("en_on_abort", {31'd0, lfsr_en}, 0);
            if (done) begin seen = 1'b1; break; end
        end
        start = 1'b0; abort = 1'b0;
        if (!seen) check("done_timeout", 0, 1);
        check("latency", c, elat);
        check("busy_at_done", {31'd0, busy}, 0);
        check("period_found", {31'd0, period_found}, {31'd0, epf});
        check("period_out", {16'd0, period_out}, eper);
        check("lockup_err", {31'd0, lockup_err}, {31'd0, elock});
        check("mux_sel", {29'd0, mux_sel}, {29'd0, esel});
        check("lfsr_seed", {27'd0, lfsr_seed}, {27'd0, eseed});
        check("load_cnt", load_cnt, (len == 0) ? 0 : 1);
        @(negedge clk);
        #3;
        check("done_pulse", {31'd0, done}, 0);
        check("bits_left", exp_q.size(), 0);
        exp_q.delete();
        zero_at = -1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_reset_outs("reset");
        nrst = 1'b1;
        do_run(5'd1, 40, 3'd0, -1, -1, -1, -1);
        do_run(5'd0, 10, 3'd2, -1, -1, -1, -1);
        do_run(5'h13, 20, 3'd3, 3, -1, -1, -1);
        do_run(5'h0A, 20, 3'd1, -1, 5, -1, -1);
        do_run(5'h05, 0, 3'd7, -1, -1, -1, -1);
        do_run(5'h07, 12, 3'd4, -1, -1, 4, -1);
        do_run(5'h09, 20, 3'd2, -1, -1, -1, 6);
        do_run(5'h03, 10, 3'd4, -1, -1, -1, -1);
        do_run(5'd1, 32, 3'd1, -1, -1, -1, -1);
        do_run(5'h11, 8, 3'd0, -1, 7, -1, -1);
        do_run(5'h16, 8, 3'd3, 7, -1, -1, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
